mtx_ch_arb: RTL and testbench
=============================

// Module: mtx_ch_arb
// PURPOSE
//   Round-robin arbiter/scheduler sharing one mtx output port among NUM_CH input channels.
//   Grants one channel at a time and locks the grant for a whole burst, ending on in_last or MAX_BURST beats.
//   Forwards beats through one registered output stage with valid/ready flow control.
//   One instance per mtx_top output column.
// PARAMETERS
//   NUM_CH      32  number of requesting input channels (>=2)
//   DATA_WIDTH  32  beat data width in bits
//   MAX_BURST   16  max beats per grant before forced release (>=1)
// PORTS
//   clk        in   1                    clock, all logic on rising edge
//   rst_n      in   1                    async active-low reset
//   in_valid   in   NUM_CH               per-channel beat valid
//   in_data    in   NUM_CH*DATA_WIDTH    per-channel data, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last    in   NUM_CH               per-channel last beat of burst
//   in_ready   out  NUM_CH               per-channel accept (combinational)
//   out_valid  out  1                    output beat valid
//   out_data   out  DATA_WIDTH           output beat data
//   out_last   out  1                    output last; copy of accepted in_last
//   out_ch     out  $clog2(NUM_CH)       source channel of output beat
//   out_ready  in   1                    downstream accept
//   busy       out  1                    1 while in LOCK state
// BEHAVIOUR
//   - Reset (async assert, sync deassert by the top): state=IDLE, ptr=NUM_CH-1, gnt=0, beat_cnt=0;
//     out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0, in_ready=0.
//   - Reset mid-burst aborts it; registered beat is dropped; no partial replay.
//   - FSM IDLE: in_ready=0. If |in_valid, winner = first set bit scanning ptr+1, ptr+2, ... modulo NUM_CH
//     (wraps NUM_CH-1 -> 0); next cycle gnt=winner, beat_cnt=0, state=LOCK. No request: stay IDLE.
//   - FSM LOCK: in_ready[gnt] = !out_valid | out_ready; all other bits 0. busy=1.
//   - Accept = in_valid[gnt] & in_ready[gnt]. On accept: out_data<=in_data[gnt], out_last<=in_last[gnt],
//     out_ch<=gnt, out_valid<=1, beat_cnt<=beat_cnt+1.
//   - Release: accept with in_last[gnt]=1 or beat_cnt==MAX_BURST-1 -> state=IDLE, ptr=gnt next cycle.
//     Forced release does not alter out_last; the channel re-arbitrates for the rest of its burst.
//   - Latency: request to grant 1 cycle; accept to out_valid 1 cycle; one IDLE bubble between grants.
//   - Output reg: out_valid cleared when out_ready=1 and no accept that cycle. Simultaneous out_ready and
//     accept: reg reloaded, out_valid stays 1; full throughput of 1 beat/cycle within a burst.
//   - out_* held stable while out_valid=1 and out_ready=0. in_ready[gnt]=0 then; no beat lost.
//   - Granted channel dropping in_valid mid-burst: grant held, no timeout; other channels wait.
//   - Requester ignores in_ready in IDLE; in_data/in_last of non-granted channels are don't-care.
//   - beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 while in LOCK.
// TESTING
//   1. After reset, in_valid=32'h0000_0005, 1-beat bursts with last=1 -> grants ch0 then ch2; out_ch 0,2;
//      ptr wraps back to scan ch3.. after ch2.
//   2. All 32 channels valid, 1-beat bursts -> out_ch sequence 0,1,...,31,0; each beat 2 cycles apart.
//   3. ch5 4-beat burst data 0xA0..0xA3, out_ready=1 -> out_data 0xA0..0xA3 on 4 consecutive cycles,
//      out_last only on 0xA3; ch6 request held off until release.
//   4. ch3 sends 20 beats, no last, MAX_BURST=16 -> release after beat 16, ch3 regranted for beats 17-20
//      (if sole requester); with ch4 also valid, ch4 is served before ch3 resumes.
//   5. Burst on ch1 with out_ready toggled 1,0,0,1,1 -> out_data stable while stalled, no drop or
//      duplicate; in_ready[1]=0 during stall.
//   6. Assert rst_n=0 mid-burst on ch7 -> all outputs 0 immediately; after release, ch0 priority first.

Source files
------------

// File: rtl/mtx_ch_arb_if.sv
// Handshake bundle between NUM_CH input channels, the arbiter and its single output port.
// The slave modport is the arbiter's view; the master modport is the view of the sources and the sink.
interface mtx_ch_arb_if #(
   parameter int NUM_CH     = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]            in_valid;
   logic [NUM_CH*DATA_WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]            in_last;
   logic [NUM_CH-1:0]            in_ready;
   logic                         out_valid;
   logic [DATA_WIDTH-1:0]        out_data;
   logic                         out_last;
   logic [CH_W-1:0]              out_ch;
   logic                         out_ready;
   logic                         busy;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_ch, busy
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_ch, busy
   );
endinterface

// File: rtl/mtx_ch_arb.sv
// Round-robin burst arbiter for one mtx output column: locks a grant for a whole burst
// and forwards its beats through a single registered valid/ready output stage.
`default_nettype none
module mtx_ch_arb #(
   parameter int NUM_CH     = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   mtx_ch_arb_if.slave bus
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                state;
   logic [CH_W-1:0]       ptr;
   logic [CH_W-1:0]       gnt;
   logic [BC_W-1:0]       beat_cnt;
   logic                  busy_q;

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;
   logic [CH_W-1:0]       ch_p1;

   logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
   logic [CH_W-1:0]       winner;
   logic                  win_vld;
   logic                  gnt_rdy;
   logic                  accept;
   logic                  release_gnt;
   logic [NUM_CH-1:0]     in_ready_c;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign ch_data[g] = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan ptr+1 .. ptr+NUM_CH (mod NUM_CH); walking downward lets the nearest requester win last.
   always_comb begin : p_pick
      int idx;
      winner  = '0;
      win_vld = |bus.in_valid;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (bus.in_valid[idx]) winner = CH_W'(idx);
      end
   end

   assign gnt_rdy     = !vld_p1 || bus.out_ready;
   assign accept      = (state == LOCK) && bus.in_valid[gnt] && gnt_rdy;
   assign release_gnt = accept && (bus.in_last[gnt] || (beat_cnt == BC_W'(MAX_BURST - 1)));

   always_comb begin
      in_ready_c = '0;
      if (state == LOCK) in_ready_c[gnt] = gnt_rdy;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_last  = last_p1;
   assign bus.out_ch    = ch_p1;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= CH_W'(NUM_CH - 1);
         gnt      <= '0;
         beat_cnt <= '0;
         busy_q   <= 1'b0;
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         last_p1  <= 1'b0;
         ch_p1    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt      <= winner;
                  beat_cnt <= '0;
                  state    <= LOCK;
                  busy_q   <= 1'b1;
               end
            end
            LOCK: begin
               if (accept) beat_cnt <= beat_cnt + BC_W'(1);
               // Forced release leaves out_last as sent; the channel simply re-arbitrates.
               if (release_gnt) begin
                  state  <= IDLE;
                  ptr    <= gnt;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // ---- output register stage ----
         if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= ch_data[gnt];
            last_p1 <= bus.in_last[gnt];
            ch_p1   <= gnt;
         end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (state == LOCK) |-> (beat_cnt < BC_W'(MAX_BURST)));
   a_onehot_rdy: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(in_ready_c));
   a_hold_out: assert property (@(posedge clk) disable iff (!rst_n)
      (vld_p1 && !bus.out_ready) |=> (vld_p1 && $stable(data_p1) && $stable(ch_p1) && $stable(last_p1)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mtx_ch_arb.sv
// Directed bench for mtx_ch_arb: simple per-channel burst sources, an output beat log,
// and one task per scenario comparing the log against hand-computed sequences.
module tb_mtx_ch_arb;
   localparam int NCH = 32;
   localparam int DW  = 32;
   localparam int MB  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mtx_ch_arb_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

   mtx_ch_arb #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // source model: remaining beats, next data word, burst length, position in burst
   int          rem      [NCH];
   logic [31:0] nd       [NCH];
   int          blen     [NCH];
   int          pos      [NCH];
   bit          use_last [NCH];

   int          log_ch   [$];
   logic [31:0] log_data [$];
   bit          log_last [$];
   int          log_cyc  [$];

   logic [NCH-1:0] snap_rdy;
   logic           snap_ov;
   logic [31:0]    snap_od;

   task automatic clear_model();
      for (int c = 0; c < NCH; c++) begin
         rem[c] = 0; nd[c] = '0; blen[c] = 1; pos[c] = 0; use_last[c] = 1'b1;
      end
   endtask

   task automatic clear_log();
      log_ch.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
   endtask

   task automatic drive_sources();
      for (int c = 0; c < NCH; c++) begin
         bus.in_valid[c]          = (rem[c] > 0);
         bus.in_data[c*DW +: DW]  = nd[c];
         bus.in_last[c]           = use_last[c] && (pos[c] == blen[c] - 1);
      end
   endtask

   task automatic cycle();
      logic [NCH-1:0] acc;
      logic [NCH-1:0] lst;
      drive_sources();
      @(negedge clk);
      acc      = bus.in_valid & bus.in_ready;
      lst      = bus.in_last;
      snap_rdy = bus.in_ready;
      snap_ov  = bus.out_valid;
      snap_od  = bus.out_data;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         log_ch.push_back(int'(bus.out_ch));
         log_data.push_back(bus.out_data);
         log_last.push_back(bus.out_last);
         log_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < NCH; c++) begin
         if (acc[c]) begin
            rem[c]--;
            nd[c]  = nd[c] + 1;
            pos[c] = lst[c] ? 0 : pos[c] + 1;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      drive_sources();
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      clear_log();
   endtask

   task automatic run_until(input int n, input int max_cyc, input string name);
      int k = 0;
      while (log_ch.size() < n && k < max_cyc) begin
         cycle();
         k++;
      end
      tests++;
      if (log_ch.size() < n) begin
         $display("FAIL %s timeout: got %0d beats, need %0d", name, log_ch.size(), n);
         fails++;
      end
   endtask

   task automatic chk_beat(input string name, input int k, input int ech, input logic [31:0] ed,
                           input bit el);
      tests++;
      if (k >= log_ch.size()) begin
         $display("FAIL %s beat %0d missing", name, k);
         fails++;
      end else if (log_ch[k] !== ech || log_data[k] !== ed || log_last[k] !== el) begin
         $display("FAIL %s beat %0d: got ch=%0d data=%h last=%0b, need ch=%0d data=%h last=%0b",
                  name, k, log_ch[k], log_data[k], log_last[k], ech, ed, el);
         fails++;
      end
   endtask

   task automatic chk_gap(input string name, input int k, input int egap);
      tests++;
      if (k >= log_cyc.size() || (log_cyc[k] - log_cyc[k-1]) !== egap) begin
         $display("FAIL %s gap before beat %0d: got %0d, need %0d", name, k,
                  (k < log_cyc.size()) ? log_cyc[k] - log_cyc[k-1] : -1, egap);
         fails++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_model();
      rem[9] = 1;
      drive_sources();
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.in_ready !== '0) begin
         $display("FAIL reset_in_ready: got %h, need 0", bus.in_ready); fails++;
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
         $display("FAIL reset_ctrl: valid=%0b last=%0b busy=%0b, need 0 0 0",
                  bus.out_valid, bus.out_last, bus.busy); fails++;
      end
      tests++;
      if (bus.out_data !== '0 || bus.out_ch !== '0) begin
         $display("FAIL reset_data: data=%h ch=%0d, need 0 0", bus.out_data, bus.out_ch); fails++;
      end
      tests++;
      if (bus.in_ready !== '0) begin
         $display("FAIL idle_in_ready: got %h, need 0", bus.in_ready); fails++;
      end
   endtask

   task automatic test_rr_basic();
      do_reset();
      rem[0] = 1; nd[0] = 32'h100;
      rem[2] = 1; nd[2] = 32'h200;
      run_until(2, 20, "rr_basic");
      chk_beat("rr_basic", 0, 0, 32'h100, 1'b1);
      chk_beat("rr_basic", 1, 2, 32'h200, 1'b1);
      tests++;
      if (log_cyc.size() < 1 || log_cyc[0] !== 2) begin
         $display("FAIL rr_latency: first beat at cycle %0d, need 2",
                  (log_cyc.size() > 0) ? log_cyc[0] : -1); fails++;
      end
      rem[0] = 1; nd[0] = 32'h101;
      rem[3] = 1; nd[3] = 32'h300;
      run_until(4, 20, "rr_wrap");
      chk_beat("rr_wrap", 2, 3, 32'h300, 1'b1);
      chk_beat("rr_wrap", 3, 0, 32'h101, 1'b1);
   endtask

   task automatic test_all_channels();
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         rem[c] = 1; nd[c] = 32'h2000 + c * 16;
      end
      rem[0] = 2;
      run_until(33, 200, "all_ch");
      for (int k = 0; k < 33; k++) begin
         chk_beat("all_ch", k, (k == 32) ? 0 : k, (k == 32) ? 32'h2001 : 32'h2000 + k * 16, 1'b1);
         if (k > 0) chk_gap("all_ch", k, 2);
      end
   endtask

   task automatic test_burst();
      do_reset();
      rem[5] = 4; nd[5] = 32'hA0; blen[5] = 4;
      rem[6] = 1; nd[6] = 32'hB0;
      run_until(5, 40, "burst");
      for (int k = 0; k < 4; k++) begin
         chk_beat("burst", k, 5, 32'hA0 + k, k == 3);
         if (k > 0) chk_gap("burst", k, 1);
      end
      chk_beat("burst", 4, 6, 32'hB0, 1'b1);
      chk_gap("burst", 4, 2);
   endtask

   task automatic test_max_burst();
      do_reset();
      rem[3] = 20; nd[3] = 32'h300; use_last[3] = 1'b0;
      run_until(20, 80, "max_solo");
      for (int k = 0; k < 20; k++) chk_beat("max_solo", k, 3, 32'h300 + k, 1'b0);
      chk_gap("max_solo", 15, 1);
      chk_gap("max_solo", 16, 2);
      do_reset();
      rem[3] = 20; nd[3] = 32'h300; use_last[3] = 1'b0;
      rem[4] = 1;  nd[4] = 32'h400;
      run_until(21, 80, "max_share");
      for (int k = 0; k < 16; k++) chk_beat("max_share", k, 3, 32'h300 + k, 1'b0);
      chk_beat("max_share", 16, 4, 32'h400, 1'b1);
      for (int k = 17; k < 21; k++) chk_beat("max_share", k, 3, 32'h300 + k - 1, 1'b0);
   endtask

   task automatic test_backpressure();
      bit pat [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      do_reset();
      rem[1] = 3; nd[1] = 32'h10; blen[1] = 3;
      for (int t = 0; t < 10; t++) begin
         bus.out_ready = pat[t];
         cycle();
         if (t == 3 || t == 4) begin
            tests++;
            if (snap_rdy[1] !== 1'b0 || snap_ov !== 1'b1 || snap_od !== 32'h11) begin
               $display("FAIL stall t=%0d: in_ready1=%0b valid=%0b data=%h, need 0 1 00000011",
                        t, snap_rdy[1], snap_ov, snap_od); fails++;
            end
         end
      end
      tests++;
      if (log_ch.size() !== 3) begin
         $display("FAIL stall_count: got %0d beats, need 3", log_ch.size()); fails++;
      end
      for (int k = 0; k < 3; k++) chk_beat("stall", k, 1, 32'h10 + k, k == 2);
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      rem[7] = 8; nd[7] = 32'h700; blen[7] = 8;
      repeat (4) cycle();
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_last !== 1'b0 ||
          bus.out_ch !== '0 || bus.busy !== 1'b0 || bus.in_ready !== '0) begin
         $display("FAIL mid_reset: valid=%0b data=%h last=%0b ch=%0d busy=%0b rdy=%h, need all 0",
                  bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, bus.busy, bus.in_ready);
         fails++;
      end
      rem[0] = 1; nd[0] = 32'hA0;
      repeat (2) cycle();
      rst_n = 1'b1;
      cyc = 0;
      clear_log();
      run_until(1, 20, "post_reset");
      chk_beat("post_reset", 0, 0, 32'hA0, 1'b1);
   endtask

   initial begin
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.in_last   = '0;
      bus.out_ready = 1'b1;
      clear_model();
      test_reset();
      test_rr_basic();
      test_all_channels();
      test_burst();
      test_max_burst();
      test_backpressure();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
